slave_port: RTL and testbench

- Serial-to-parallel receiver between the system bus and a write-only slave (memory or peripheral).
- Consumes the bit-serial write transaction the bus forwards after address decode:
  - ADDR_W-DATA_W address-only beats first.
  - Then DATA_W beats, each carrying one address bit and one write-data bit in parallel.
  - All bits arrive MSB-first.
- Once all bits are received, presents the assembled local address and data word to the slave with a valid/ready handshake.
- Back-pressures the bus while the slave has not yet accepted the word.

---
 rtl/slave_port.sv | 95 +++++++++
 tb/tb_slave_port.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/slave_port.sv
// slave_port: bit-serial write receiver that assembles address/data and hands them to a write-only slave
module slave_port #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sp_addr,
    input  logic              sp_wdata,
    input  logic              sp_valid,
    output logic              sp_ready,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    output logic              s_valid,
    input  logic              s_ready,
    output logic              abort
);
    localparam int H  = ADDR_W - DATA_W;
    localparam int CW = $clog2(ADDR_W + 1);
    localparam int IW = $clog2(TIMEOUT + 2);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RX_ADDR = 2'd1;
    localparam logic [1:0] RX_DATA = 2'd2;
    localparam logic [1:0] WRITE   = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [IW-1:0]     idle_q, idle_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              abort_q, abort_d;
    logic              beat, rx, timeout;

    assign sp_ready = state_q != WRITE;
    assign beat     = sp_valid && sp_ready;
    assign rx       = state_q == RX_ADDR || state_q == RX_DATA;
    // fires on the stall cycle that brings the idle count up to TIMEOUT
    assign timeout  = TIMEOUT != 0 && rx && !sp_valid && idle_q == IW'(TIMEOUT - 1);

    assign s_addr  = addr_q;
    assign s_wdata = wdata_q;
    assign s_valid = state_q == WRITE;
    assign abort   = abort_q;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        idle_d  = (rx && !sp_valid) ? idle_q + 1'b1 : '0;
        abort_d = timeout;
        if (beat) begin
            addr_d  = {addr_q[ADDR_W-2:0], sp_addr};
            count_d = count_q + 1'b1;
        end
        if (beat && state_q == RX_DATA)
            wdata_d = {wdata_q[DATA_W-2:0], sp_wdata};
        case (state_q)
            IDLE:    if (beat) state_d = (H == 1) ? RX_DATA : RX_ADDR;
            RX_ADDR: if (beat && count_q == CW'(H - 1)) state_d = RX_DATA;
            RX_DATA: if (beat && count_q == CW'(ADDR_W - 1)) state_d = WRITE;
            default: begin
                if (s_ready) begin
                    state_d = IDLE;
                    count_d = '0;
                end
            end
        endcase
        if (timeout) begin
            state_d = IDLE;
            count_d = '0;
            idle_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            idle_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idle_q  <= idle_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            abort_q <= abort_d;
        end
    end
endmodule

// File: tb/tb_slave_port.sv
// tb_slave_port: randomized and directed checks of slave_port against a beat-counting reference model
module tb_slave_port;
    localparam int AW = 12;
    localparam int DW = 8;
    localparam int TO = 16;
    localparam int H  = AW - DW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sp_addr = 1'b0;
    logic          sp_wdata = 1'b0;
    logic          sp_valid = 1'b0;
    logic          sp_ready;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata;
    logic          s_valid;
    logic          s_ready;
    logic          abort;
    logic          s_ready_dir = 1'b1;
    logic          s_ready_rnd = 1'b1;
    logic          rand_ready = 1'b0;
    logic          started = 1'b0;

    int ncmp = 0;
    int nfail = 0;

    assign s_ready = rand_ready ? s_ready_rnd : s_ready_dir;

    slave_port #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .sp_addr(sp_addr), .sp_wdata(sp_wdata), .sp_valid(sp_valid),
        .sp_ready(sp_ready), .s_addr(s_addr), .s_wdata(s_wdata), .s_valid(s_valid),
        .s_ready(s_ready), .abort(abort)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: counts accepted beats, accumulates the word arithmetically, owes a write after AW beats
    int            m_n = 0;
    int            m_idle = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0;
    logic          m_wr = 1'b0;
    logic          m_abort = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_n = 0; m_idle = 0; m_addr = '0; m_data = '0; m_wr = 1'b0; m_abort = 1'b0;
        end else begin
            m_abort = 1'b0;
            if (m_wr) begin
                if (s_ready) begin m_wr = 1'b0; m_n = 0; end
            end else if (sp_valid) begin
                m_addr = (m_addr << 1) | AW'(sp_addr);
                if (m_n >= H) m_data = (m_data << 1) | DW'(sp_wdata);
                m_n++;
                m_idle = 0;
                if (m_n == AW) m_wr = 1'b1;
            end else if (m_n > 0) begin
                m_idle++;
                if (m_idle == TO) begin m_abort = 1'b1; m_n = 0; m_idle = 0; end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("sp_ready", 32'(sp_ready), 32'(!m_wr));
            chk("s_valid", 32'(s_valid), 32'(m_wr));
            chk("abort", 32'(abort), 32'(m_abort));
            if (m_wr) begin
                chk("s_addr", 32'(s_addr), 32'(m_addr));
                chk("s_wdata", 32'(s_wdata), 32'(m_data));
            end
        end
    end

    // Write/abort monitor used by the hand-computed checks
    logic [AW+DW-1:0] wq[$];
    int cyc = 0;
    int wcyc = 0;
    int nab = 0;

    always @(posedge clk) begin
        cyc++;
        if (s_valid && s_ready) begin
            wq.push_back({s_addr, s_wdata});
            wcyc = cyc;
        end
        if (abort) nab++;
    end

    initial s_ready_rnd = 1'b1;
    always @(negedge clk) s_ready_rnd <= ($urandom_range(0, 3) != 0);

    task automatic beat_bit(input logic a, input logic d);
        int guard = 0;
        sp_addr = a;
        sp_wdata = d;
        sp_valid = 1'b1;
        while (!sp_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            nfail++;
            $display("FAIL beat_wait: sp_ready stuck at 0 for %0d cycles", guard);
        end
        @(negedge clk);
    endtask

    task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int stall_after, input int stall_len, input int rst_at);
        for (int i = 0; i < AW; i++) begin
            logic wb;
            wb = (i >= H) ? d[AW-1-i] : 1'($urandom_range(0, 1));
            if (i == rst_at - 1) begin
                rst = 1'b1;
                beat_bit(a[AW-1-i], wb);
                rst = 1'b0;
                sp_valid = 1'b0;
                return;
            end
            beat_bit(a[AW-1-i], wb);
            if (i + 1 == stall_after && stall_len > 0) begin
                sp_valid = 1'b0;
                for (int k = 0; k < stall_len; k++) begin
                    sp_addr = 1'($urandom_range(0, 1));
                    @(negedge clk);
                end
            end
        end
        sp_valid = 1'b0;
    endtask

    task automatic expect_last(input string name, input int back, input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic [AW+DW-1:0] got;
        got = (wq.size() > back) ? wq[wq.size()-1-back] : '1;
        chk(name, 32'(got), 32'({a, d}));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, tb_lat, ts_lat, nab0, nwr0, at;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        started = 1'b1;
        chk("reset_s_valid", 32'(s_valid), 32'd0);
        chk("reset_s_addr", 32'(s_addr), 32'd0);
        chk("reset_s_wdata", 32'(s_wdata), 32'd0);
        chk("reset_sp_ready", 32'(sp_ready), 32'd1);
        chk("reset_abort", 32'(abort), 32'd0);

        t0 = cyc;
        send(12'hA5C, 8'h3C, 0, 0, 0);
        chk("basic_valid", 32'(s_valid), 32'd1);
        chk("basic_addr", 32'(s_addr), 32'hA5C);
        chk("basic_wdata", 32'(s_wdata), 32'h3C);
        @(negedge clk);
        tb_lat = wcyc - t0;
        chk("basic_pulse_end", 32'(s_valid), 32'd0);
        expect_last("basic_write", 0, 12'hA5C, 8'h3C);

        nab0 = nab;
        t0 = cyc;
        send(12'hA5C, 8'h3C, 6, 3, 0);
        @(negedge clk);
        ts_lat = wcyc - t0;
        chk("stall_delay", 32'(ts_lat - tb_lat), 32'd3);
        expect_last("stall_write", 0, 12'hA5C, 8'h3C);
        chk("stall_no_abort", 32'(nab - nab0), 32'd0);

        s_ready_dir = 1'b0;
        send(12'h7E1, 8'h96, 0, 0, 0);
        fork
            send(12'h001, 8'hFF, 0, 0, 0);
            begin
                int bad;
                bad = 0;
                for (int k = 1; k <= 6; k++) begin
                    if (k == 6) s_ready_dir = 1'b1;
                    if (!(s_valid && !sp_ready && s_addr == 12'h7E1 && s_wdata == 8'h96)) bad++;
                    @(negedge clk);
                end
                chk("bp_hold_cycles_bad", 32'(bad), 32'd0);
                chk("bp_release_ready", 32'(sp_ready), 32'd1);
            end
        join
        send(12'hFFF, 8'h00, 0, 0, 0);
        @(negedge clk);
        expect_last("bp_write", 2, 12'h7E1, 8'h96);
        expect_last("b2b_first", 1, 12'h001, 8'hFF);
        expect_last("b2b_second", 0, 12'hFFF, 8'h00);

        nwr0 = wq.size();
        send(12'h3AB, 8'h11, 0, 0, 9);
        chk("rst_mid_valid", 32'(s_valid), 32'd0);
        chk("rst_mid_addr", 32'(s_addr), 32'd0);
        chk("rst_mid_wdata", 32'(s_wdata), 32'd0);
        chk("rst_mid_ready", 32'(sp_ready), 32'd1);
        send(12'h123, 8'h45, 0, 0, 0);
        @(negedge clk);
        chk("rst_mid_one_write", 32'(wq.size() - nwr0), 32'd1);
        expect_last("rst_then_write", 0, 12'h123, 8'h45);

        nab0 = nab;
        nwr0 = wq.size();
        for (int i = 0; i < 5; i++) beat_bit(1'($urandom_range(0, 1)), 1'b0);
        sp_valid = 1'b0;
        at = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (abort && at == 0) at = k;
        end
        chk("timeout_cycle", 32'(at), 32'd16);
        chk("timeout_pulses", 32'(nab - nab0), 32'd1);
        chk("timeout_no_write", 32'(wq.size() - nwr0), 32'd0);
        send(12'h5A5, 8'hC3, 0, 0, 0);
        @(negedge clk);
        expect_last("timeout_then_write", 0, 12'h5A5, 8'hC3);

        rand_ready = 1'b1;
        for (int t = 0; t < 40; t++) begin
            int sa, sl;
            sa = $urandom_range(1, AW);
            sl = ($urandom_range(0, 7) == 0) ? $urandom_range(14, 20) : $urandom_range(0, 4);
            send(AW'($urandom), DW'($urandom), sa, sl, 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        sp_valid = 1'b0;
        rand_ready = 1'b0;
        s_ready_dir = 1'b1;
        repeat (25) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
